// File: rtl/delay_line_mc.sv
// Multi-channel programmable sample delay line: per-lane delay of 0..DEPTH-1 accepted
// samples over a shared circular buffer, with zero-masking of not-yet-filled history.
module delay_line_mc #(
  parameter int WIDTH           = 32,
  parameter int CHANNELS        = 2,
  parameter int DEPTH           = 64,
  parameter int UPR_W           = 8,
  parameter int FLUSH_ON_CHANGE = 1
) (
  input  logic                                               clk,
  input  logic                                               srstb,
  input  logic                                               in_en,
  input  logic [CHANNELS*WIDTH-1:0]                          Idat,
  input  logic                                               wr_comm,
  input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] ch_sel,
  input  logic [UPR_W-1:0]                                   upr,
  output logic [CHANNELS*WIDTH-1:0]                          Odat,
  output logic                                               Ovalid,
  output logic                                               cfg_err
);
  localparam int SEL_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = (UPR_W > AW) ? UPR_W : AW;
  localparam logic [AW-1:0]  MAX_D = AW'(DEPTH - 1);
  localparam logic [CW-1:0]  MAX_C = CW'(DEPTH - 1);
  localparam logic [SEL_W:0] NCH   = (SEL_W + 1)'(CHANNELS);

  // Fill counter saturates at DEPTH-1, the largest delay that can ever be requested.
  function automatic logic [AW-1:0] sat_inc(input logic [AW-1:0] v);
    return (v == MAX_D) ? v : v + AW'(1);
  endfunction

  function automatic logic [AW-1:0] clamp_dly(input logic [UPR_W-1:0] req);
    logic [CW-1:0] ext;
    ext = CW'(req);
    return (ext > MAX_C) ? MAX_D : ext[AW-1:0];
  endfunction

  logic [AW-1:0]             r_wr_ptr;
  logic [AW-1:0]             r_dly  [CHANNELS];
  logic [AW-1:0]             r_fill [CHANNELS];
  logic [WIDTH-1:0]          r_mem  [CHANNELS][DEPTH];
  logic [CHANNELS*WIDTH-1:0] r_odat_p1;
  logic                      r_vld_p1;
  logic                      r_err_p1;

  logic [WIDTH-1:0]          w_lane    [CHANNELS];
  logic [AW-1:0]             w_rd_addr [CHANNELS];
  logic                      w_sel_ok;
  logic                      w_over;
  logic [AW-1:0]             w_new_dly;

  assign w_sel_ok  = ({1'b0, ch_sel} < NCH);
  assign w_over    = (CW'(upr) > MAX_C);
  assign w_new_dly = clamp_dly(upr);

  // Stage 0: select bypass, masked zero, or buffered history per lane.
  // A non-zero delay never addresses the slot being written this cycle.
  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      w_rd_addr[c] = r_wr_ptr - r_dly[c];
      w_lane[c]    = '0;
      if (r_dly[c] == '0)
        w_lane[c] = Idat[c*WIDTH +: WIDTH];
      else if (r_fill[c] >= r_dly[c])
        w_lane[c] = r_mem[c][w_rd_addr[c]];
    end
  end

  always_ff @(posedge clk) begin
    if (in_en) begin
      for (int c = 0; c < CHANNELS; c++)
        r_mem[c][r_wr_ptr] <= Idat[c*WIDTH +: WIDTH];
    end
  end

  // Stage 1: registered output, pointer/fill bookkeeping and command handling.
  always_ff @(posedge clk) begin
    if (!srstb) begin
      r_wr_ptr  <= '0;
      r_odat_p1 <= '0;
      r_vld_p1  <= 1'b0;
      r_err_p1  <= 1'b0;
      for (int c = 0; c < CHANNELS; c++) begin
        r_dly[c]  <= '0;
        r_fill[c] <= '0;
      end
    end else begin
      r_vld_p1 <= in_en;
      r_err_p1 <= wr_comm && (!w_sel_ok || w_over);
      if (in_en)
        r_wr_ptr <= r_wr_ptr + AW'(1);
      for (int c = 0; c < CHANNELS; c++) begin
        if (in_en) begin
          r_odat_p1[c*WIDTH +: WIDTH] <= w_lane[c];
          r_fill[c]                   <= sat_inc(r_fill[c]);
        end
        // A changed delay restarts the fill count, overriding this edge's increment.
        if (wr_comm && w_sel_ok && (ch_sel == SEL_W'(c))) begin
          r_dly[c] <= w_new_dly;
          if ((FLUSH_ON_CHANGE != 0) && (w_new_dly != r_dly[c]))
            r_fill[c] <= '0;
        end
      end
    end
  end

  assign Odat    = r_odat_p1;
  assign Ovalid  = r_vld_p1;
  assign cfg_err = r_err_p1;

endmodule

// File: tb/tb_delay_line_mc.sv
// Bench for delay_line_mc: two instances (2 lanes with flush, 3 lanes without flush)
// driven together and compared every cycle against a sample-history reference model.
module tb_delay_line_mc;
  localparam int W = 32;
  localparam int D = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           srstb, in_en, wr_a, wr_b;
  logic [0:0]     sel_a;
  logic [1:0]     sel_b;
  logic [7:0]     upr;
  logic [3*W-1:0] idat;
  logic [2*W-1:0] odat_a;
  logic [3*W-1:0] odat_b;
  logic           ov_a, ov_b, err_a, err_b;

  delay_line_mc #(.WIDTH(W), .CHANNELS(2), .DEPTH(D), .UPR_W(8), .FLUSH_ON_CHANGE(1)) u_a (
    .clk(clk), .srstb(srstb), .in_en(in_en), .Idat(idat[2*W-1:0]), .wr_comm(wr_a),
    .ch_sel(sel_a), .upr(upr), .Odat(odat_a), .Ovalid(ov_a), .cfg_err(err_a));

  delay_line_mc #(.WIDTH(W), .CHANNELS(3), .DEPTH(D), .UPR_W(8), .FLUSH_ON_CHANGE(0)) u_b (
    .clk(clk), .srstb(srstb), .in_en(in_en), .Idat(idat), .wr_comm(wr_b),
    .ch_sel(sel_b), .upr(upr), .Odat(odat_b), .Ovalid(ov_b), .cfg_err(err_b));

  int checks   = 0;
  int failures = 0;

  int nch[2]   = '{2, 3};
  int flush[2] = '{1, 0};
  int         m_dly  [2][3];
  int         m_fill [2][3];
  logic [W-1:0] m_hist [6][$];
  logic [W-1:0] e_out  [2][3];
  logic         e_vld  [2];
  logic         e_err  [2];

  // Reference: each lane remembers its accepted samples; output is the sample d back,
  // or zero while fewer than d samples have been counted since reset/flush.
  task automatic model_edge();
    logic [W-1:0] s;
    int h, sel, nd;
    logic wr;
    for (int k = 0; k < 2; k++) begin
      if (!srstb) begin
        e_vld[k] = 1'b0;
        e_err[k] = 1'b0;
        for (int c = 0; c < 3; c++) begin
          m_dly[k][c]  = 0;
          m_fill[k][c] = 0;
          e_out[k][c]  = '0;
          m_hist[k*3+c].delete();
        end
      end else begin
        e_vld[k] = in_en;
        e_err[k] = 1'b0;
        if (in_en) begin
          for (int c = 0; c < nch[k]; c++) begin
            s = idat[c*W +: W];
            h = k*3 + c;
            if (m_dly[k][c] == 0)
              e_out[k][c] = s;
            else if (m_fill[k][c] < m_dly[k][c])
              e_out[k][c] = '0;
            else
              e_out[k][c] = m_hist[h][m_hist[h].size() - m_dly[k][c]];
            m_hist[h].push_back(s);
            if (m_hist[h].size() > D)
              void'(m_hist[h].pop_front());
            if (m_fill[k][c] < D-1)
              m_fill[k][c]++;
          end
        end
        wr  = (k == 0) ? wr_a : wr_b;
        sel = (k == 0) ? int'(sel_a) : int'(sel_b);
        if (wr) begin
          if (sel >= nch[k]) begin
            e_err[k] = 1'b1;
          end else begin
            nd       = (int'(upr) > D-1) ? D-1 : int'(upr);
            e_err[k] = (int'(upr) > D-1);
            if (flush[k] != 0 && nd != m_dly[k][sel])
              m_fill[k][sel] = 0;
            m_dly[k][sel] = nd;
          end
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("a_valid", W'(ov_a), W'(e_vld[0]));
    chk("a_cfg_err", W'(err_a), W'(e_err[0]));
    chk("b_valid", W'(ov_b), W'(e_vld[1]));
    chk("b_cfg_err", W'(err_b), W'(e_err[1]));
    for (int c = 0; c < 2; c++)
      chk($sformatf("a_odat%0d", c), odat_a[c*W +: W], e_out[0][c]);
    for (int c = 0; c < 3; c++)
      chk($sformatf("b_odat%0d", c), odat_b[c*W +: W], e_out[1][c]);
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic stream(input int first, input int n, input int cmd_at, input int csel,
                        input int cupr);
    for (int i = 0; i < n; i++) begin
      in_en = 1'b1;
      for (int c = 0; c < 3; c++)
        idat[c*W +: W] = W'(first + i);
      if (i == cmd_at) begin
        wr_a = 1'b1; wr_b = 1'b1;
        sel_a = 1'(csel); sel_b = 2'(csel); upr = 8'(cupr);
      end
      cyc();
      wr_a = 1'b0; wr_b = 1'b0;
    end
    in_en = 1'b0;
  endtask

  task automatic cmd(input int csel, input int cupr, input bit to_a, input bit to_b);
    wr_a = to_a; wr_b = to_b;
    sel_a = 1'(csel); sel_b = 2'(csel); upr = 8'(cupr);
    cyc();
    wr_a = 1'b0; wr_b = 1'b0;
    cyc();
  endtask

  initial begin
    bit pat[7] = '{1, 0, 0, 1, 1, 0, 1};
    int v;
    srstb = 1'b0; in_en = 1'b0; wr_a = 1'b0; wr_b = 1'b0;
    sel_a = '0; sel_b = '0; upr = '0; idat = '0;
    cyc();
    cyc();
    srstb = 1'b1;
    cyc();

    // Plan 1/2: lane1 d=1 then d=3 against bypass lane0
    cmd(1, 1, 1'b1, 1'b1);
    stream(1, 32, -1, 0, 0);
    cyc();
    cmd(1, 3, 1'b1, 1'b1);
    stream(1, 32, -1, 0, 0);

    // Plan 3: clamp to 63, then an out-of-range lane on the 3-lane instance
    cmd(1, 200, 1'b1, 1'b1);
    stream(1, 100, -1, 0, 0);
    cmd(3, 5, 1'b0, 1'b1);
    stream(101, 4, -1, 0, 0);

    // Plan 4: change on the 10th sample, then rewrite of the same value
    cmd(0, 2, 1'b1, 1'b1);
    stream(1, 20, 9, 0, 5);
    cmd(0, 2, 1'b1, 1'b1);
    stream(1, 20, 9, 0, 2);

    // Plan 5: gapped input, then pointer wrap at maximum delay
    v = 1;
    for (int i = 0; i < 7; i++) begin
      in_en = pat[i];
      for (int c = 0; c < 3; c++)
        idat[c*W +: W] = W'(v);
      if (pat[i]) v++;
      cyc();
    end
    in_en = 1'b0;
    cyc();
    cmd(0, 63, 1'b1, 1'b1);
    stream(1, 200, -1, 0, 0);

    // Plan 6: reset in the middle of a d=4 stream
    cmd(0, 4, 1'b1, 1'b1);
    stream(1, 10, -1, 0, 0);
    srstb = 1'b0; in_en = 1'b1;
    cyc();
    srstb = 1'b1; in_en = 1'b0;
    chk("post_reset_odat", odat_a[W-1:0], '0);
    stream(1, 5, -1, 0, 0);

    // Randomized traffic with distinct per-lane data, commands and occasional reset
    for (int i = 0; i < 3000; i++) begin
      srstb = ($urandom_range(0, 299) != 0);
      in_en = ($urandom_range(0, 9) < 7);
      for (int c = 0; c < 3; c++)
        idat[c*W +: W] = $urandom();
      wr_a  = ($urandom_range(0, 19) == 0);
      wr_b  = ($urandom_range(0, 19) == 0);
      sel_a = 1'($urandom_range(0, 1));
      sel_b = 2'($urandom_range(0, 3));
      upr   = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                          : 8'($urandom_range(0, 8));
      cyc();
    end
    srstb = 1'b1; in_en = 1'b0; wr_a = 1'b0; wr_b = 1'b0;
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/delay_line_mc.md
Name: delay_line_mc

Overview:
Multi-channel programmable sample delay line, the parametrised successor of the single-channel 32-bit delay block. Each of CHANNELS lanes delays its WIDTH-bit sample stream by a runtime-programmable number of accepted samples, from 0 to DEPTH-1. Delay is counted in samples qualified by in_en, not in clock cycles. Lanes share one write pointer, have independent delays, and mask stale history with zeros. It sits in the data path ahead of channel combining, to align channel timing.

Parameters:
WIDTH, 32, sample width per channel
CHANNELS, 2, number of lanes (>=1)
DEPTH, 64, buffer entries per lane; max delay = DEPTH-1 (power of 2, >=2)
UPR_W, 8, width of the delay command word
FLUSH_ON_CHANGE, 1, 1 = lane outputs zeros until refilled after a delay change; 0 = new delay applies immediately to existing history

Ports:
clk  in  1  clock
srstb  in  1  synchronous reset, active low
in_en  in  1  sample strobe, common to all lanes
Idat  in  CHANNELS*WIDTH  input samples; lane c = Idat[c*WIDTH +: WIDTH]
wr_comm  in  1  one-cycle delay-write strobe
ch_sel  in  max(1,$clog2(CHANNELS))  lane addressed by wr_comm
upr  in  UPR_W  requested delay in samples
Odat  out  CHANNELS*WIDTH  delayed samples, same packing as Idat
Ovalid  out  1  Odat valid strobe
cfg_err  out  1  one-cycle pulse on a clamped or invalid command

Behaviour:
- Reset (srstb=0 at a clk edge) sets: Odat=0, Ovalid=0, cfg_err=0, wr_ptr=0, all lane delays=0, all fill counters=0. Buffer RAM is not cleared; fill masking hides its contents.
- Reset asserted mid-stream aborts everything. The first sample accepted after reset is sample 0 of a fresh stream.
- Sample accept: in_en=1 at edge t writes every lane's Idat to mem[c][wr_ptr]. wr_ptr then increments modulo DEPTH and wraps DEPTH-1 to 0.
- Output timing:
  - Ovalid at edge t+1 is the registered in_en from edge t. Latency is exactly 1 cycle.
  - With lane delay d, Odat lane c at t+1 = the sample accepted d samples before the current one.
  - d=0 is a bypass: Odat = Idat registered. It must not read a not-yet-written RAM location.
- Idle cycles: when in_en=0, Ovalid=0 and Odat holds its last value.
- Fill masking:
  - fill[c] counts accepted samples and saturates at DEPTH-1.
  - If fill[c] < d, lane c outputs 0 for that sample. Otherwise it outputs the delayed sample.
  - fill[c] increments after the output decision for the current sample.
- Command write, wr_comm=1 at edge t:
  - Lane ch_sel takes delay min(upr, DEPTH-1), effective from the first sample accepted after edge t.
  - A sample accepted on the same edge t uses the old delay.
  - upr > DEPTH-1: value is clamped and cfg_err pulses at t+1.
  - ch_sel >= CHANNELS: command is ignored and cfg_err pulses at t+1.
  - FLUSH_ON_CHANGE=1 and the lane's delay value changes: fill[ch_sel] is cleared after edge t, and the same-edge sample is not counted.
  - Rewriting the current delay value never flushes.
  - FLUSH_ON_CHANGE=0: fill is untouched.
- Independence: lanes do not interact. A command to one lane never changes another lane's output.
- Data arithmetic: none; samples pass bit-exact. Read address = (wr_ptr - d) mod DEPTH, using $clog2(DEPTH)-bit wrap-around arithmetic.

Test Plan:
1. Reset; ch0 d=0, ch1 d=1; drive in_en=1 with both lanes 1..32 on consecutive cycles. Required: Ovalid high for 32 cycles, one cycle after in_en. Odat0 = 1..32. Odat1 = 0,1,2..31.
2. ch1 d=3; stream 1..32 on both lanes. Required: Odat1 = 0,0,0,1..29. Odat0 stays bit-exact.
3. ch1 upr=200 with DEPTH=64. Required: cfg_err one pulse; delay becomes 63. Stream 1..100 on ch1: first 63 outputs are 0, output #64 = 1, output #100 = 37. Separately, ch_sel=2 with CHANNELS=2: cfg_err pulses and no lane delay changes.
4. ch0 d=2; stream 1..20; wr_comm upr=5 on the same edge as sample 10.
   - FLUSH=1: outputs 0,0,1..8; sample 10 -> 8; samples 11..15 -> 0; sample 16 -> 11.
   - FLUSH=0: sample 11 -> 6.
   - Same stream with upr=2 rewritten: no flush occurs.
5. Gapped input, in_en pattern 1,0,0,1,1,0,1 with d=2 and samples 1..4. Required: Ovalid follows the pattern delayed by 1 cycle. Odat = 0,0,1,2, holding its last value during gaps. Wrap check: stream 200 samples at d=63 and check output k = k-63 across every pointer wrap.
6. srstb low for 1 cycle mid-stream at d=4. Required: Odat=0, Ovalid=0, all delays 0 after reset. The next stream 1..5 outputs 1..5 (d=0), with no stale pre-reset data visible.
